// File: rtl/tnn_pkg.sv
// Shared constants and types for the 2-bit-input neuron feature packers.
package tnn_pkg;

  localparam int NUM_FEAT = 8;
  localparam int RAW_W    = 8;
  localparam int Q_W      = 2;
  localparam int CNT_W    = 16;
  localparam int IDX_W    = $clog2(NUM_FEAT);

  localparam logic [RAW_W-1:0] T1_DEF = 8'd64;
  localparam logic [RAW_W-1:0] T2_DEF = 8'd128;
  localparam logic [RAW_W-1:0] T3_DEF = 8'd192;

  typedef logic [NUM_FEAT*Q_W-1:0] feat_vec_t;
  typedef logic [Q_W-1:0]          q_t;

  typedef enum logic {ST_FILL, ST_PEND} pack_state_t;

endpackage

// File: rtl/tnn_quantizer.sv
// Fixed-threshold 8-bit -> 2-bit quantizer; thresholds are per-dataset parameters.
module tnn_quantizer
  import tnn_pkg::*;
#(
  parameter logic [RAW_W-1:0] T1 = T1_DEF,
  parameter logic [RAW_W-1:0] T2 = T2_DEF,
  parameter logic [RAW_W-1:0] T3 = T3_DEF
) (
  input  logic [RAW_W-1:0] x,
  output q_t               q
);

  always_comb begin
    q = 2'd0;
    if (x >= T3)      q = 2'd3;
    else if (x >= T2) q = 2'd2;
    else if (x >= T1) q = 2'd1;
  end

endmodule

// File: rtl/tnn_feature_packer.sv
// Packs a serial stream of quantized features into one vector per frame,
// with one pending frame buffer behind the valid/ready output register.
//
// state   | meaning
// ST_FILL | assembling a frame, s_ready=1
// ST_PEND | complete frame parked in asm, waiting for the output slot
module tnn_feature_packer
  import tnn_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [RAW_W-1:0]      s_data,
  input  logic                  s_last,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [NUM_FEAT*Q_W-1:0] m_vec,
  output logic                  err_pulse,
  output logic [CNT_W-1:0]      frame_cnt
);

  pack_state_t      state;
  logic [IDX_W-1:0] idx;
  feat_vec_t        asm_vec;
  feat_vec_t        full_vec;
  q_t               q;
  logic             accept;
  logic             last_idx;
  logic             complete;
  logic             early_last;
  logic             slot_free;

  tnn_quantizer u_quant (
    .x (s_data),
    .q (q)
  );

  // s_ready depends only on registered state, never on m_ready.
  assign s_ready    = (state == ST_FILL);
  assign accept     = s_valid && s_ready;
  assign last_idx   = (idx == IDX_W'(NUM_FEAT - 1));
  assign complete   = accept && last_idx;
  assign early_last = accept && s_last && !last_idx;
  assign slot_free  = !m_valid || m_ready;

  always_comb begin
    full_vec = asm_vec;
    full_vec[idx*Q_W +: Q_W] = q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_FILL;
      idx       <= '0;
      asm_vec   <= '0;
      m_valid   <= 1'b0;
      m_vec     <= '0;
      err_pulse <= 1'b0;
      frame_cnt <= '0;
    end else begin
      err_pulse <= accept && (s_last != last_idx);

      if (accept) begin
        if (last_idx || s_last) idx <= '0;
        else                    idx <= idx + IDX_W'(1);
        if (early_last) asm_vec <= '0;
        else            asm_vec <= full_vec;
      end

      if (complete && slot_free) begin
        m_vec   <= full_vec;
        m_valid <= 1'b1;
        if (frame_cnt != '1) frame_cnt <= frame_cnt + CNT_W'(1);
      end else if (complete) begin
        state <= ST_PEND;
      end else if (state == ST_PEND && m_valid && m_ready) begin
        m_vec <= asm_vec;
        state <= ST_FILL;
        if (frame_cnt != '1) frame_cnt <= frame_cnt + CNT_W'(1);
      end else if (m_valid && m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

endmodule
